// File: rtl/display_pkg.sv
// Shared constants, digit payload type and enable-polarity helper for the display path.
package display_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned DEF_SCAN_DIV  = 1000;
    localparam int unsigned DEF_GHOST_CYC = 16;

    typedef struct packed {
        logic [DIGIT_W-1:0] code;
        logic               dp;
    } digit_t;

    // Map a logical "enable on" to the pin level for the chosen driver polarity.
    function automatic logic en_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the multiplexed display; emits registered slot decodes.
module scan_timer
    import display_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS = 4,
    parameter  int unsigned SCAN_DIV   = DEF_SCAN_DIV,
    parameter  int unsigned GHOST_CYC  = DEF_GHOST_CYC,
    localparam int unsigned CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             slot_zero_o,
    output logic             slot_en_window_o,
    output logic             frame_boundary_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_zero_q, window_q, boundary_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Decodes are computed from the next count so they line up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            slot_zero_q <= 1'b1;
            window_q    <= 1'b0;
            boundary_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            slot_zero_q <= (cnt_d == '0);
            window_q    <= (cnt_d >= CNT_GHOST);
            boundary_q  <= (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        end
    end

    assign digit_idx_o      = idx_q;
    assign slot_zero_o      = slot_zero_q;
    assign slot_en_window_o = window_q;
    assign frame_boundary_o = boundary_q;

endmodule

// File: rtl/digit_scan.sv
// Multiplexed BCD display driver: frame-synchronous load, leading-zero blanking,
// dead-time between digits, and decoder-aligned digit enables.
module digit_scan
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SCAN_DIV      = DEF_SCAN_DIV,
    parameter int unsigned GHOST_CYC     = DEF_GHOST_CYC,
    parameter bit          EN_ACTIVE_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          lzb_en,
    output logic [DIGIT_W-1:0]            dec,
    output logic                          dp_o,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          pending,
    output logic                          frame_start
);

    localparam int unsigned           BCD_W  = DIGIT_W * NUM_DIGITS;
    localparam int unsigned           IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW}};

    logic [IDX_W-1:0]      digit_idx;
    logic                  slot_zero, en_window, frame_boundary;

    logic [BCD_W-1:0]      staged_bcd_q, staged_bcd_d;
    logic [NUM_DIGITS-1:0] staged_dp_q, staged_dp_d;
    logic [BCD_W-1:0]      shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;

    digit_t                disp_q, disp_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  frame_start_q, frame_start_d;

    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;
    logic [DIGIT_W-1:0]    cur_code;
    logic                  cur_dp, cur_blank;
    logic [NUM_DIGITS-1:0] cur_onehot;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .GHOST_CYC  (GHOST_CYC)
    ) u_scan_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .digit_idx_o      (digit_idx),
        .slot_zero_o      (slot_zero),
        .slot_en_window_o (en_window),
        .frame_boundary_o (frame_boundary)
    );

    // Staged/shadow handshake: the shown value only changes at a frame boundary.
    always_comb begin
        staged_bcd_d = staged_bcd_q;
        staged_dp_d  = staged_dp_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (frame_boundary) begin
            if (load) begin
                shadow_bcd_d = bcd_in;
                shadow_dp_d  = dp_in;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                shadow_bcd_d = staged_bcd_q;
                shadow_dp_d  = staged_dp_q;
                pending_d    = 1'b0;
            end
        end else if (load) begin
            staged_bcd_d = bcd_in;
            staged_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
    end

    // A digit blanks while it and everything above it are zero without a dp.
    always_comb begin
        blank    = '0;
        zero_run = lzb_en;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (shadow_bcd_q[i*DIGIT_W +: DIGIT_W] == '0)
                       && !shadow_dp_q[i];
            blank[i] = zero_run;
        end
    end

    always_comb begin
        cur_code   = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_code      = shadow_bcd_q[i*DIGIT_W +: DIGIT_W];
                cur_dp        = shadow_dp_q[i];
                cur_blank     = blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        disp_d        = disp_q;
        frame_start_d = 1'b0;
        en_d          = EN_OFF;
        if (slot_zero) begin
            disp_d.code   = cur_code;
            disp_d.dp     = cur_dp;
            frame_start_d = (digit_idx == '0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            en_d[i] = en_level(cur_onehot[i] && en_window && !cur_blank, EN_ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_bcd_q  <= '0;
            staged_dp_q   <= '0;
            shadow_bcd_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            disp_q        <= '0;
            en_q          <= EN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            staged_bcd_q  <= staged_bcd_d;
            staged_dp_q   <= staged_dp_d;
            shadow_bcd_q  <= shadow_bcd_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            disp_q        <= disp_d;
            en_q          <= en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dec         = disp_q.code;
    assign dp_o        = disp_q.dp;
    assign digit_en    = en_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan.sv
// Scoreboard bench for digit_scan with a 4-digit, 8-cycle-slot, 2-cycle dead-time setup.
module tb_digit_scan;

    typedef struct packed {
        logic [3:0] dec;
        logic       dp;
        logic       on;
    } slot_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;
    logic [3:0]  dec;
    logic        dp_o;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    slot_exp_t  exp_q[$];
    logic [3:0] obs_dec [32];
    logic       obs_dp  [32];
    logic [3:0] obs_en  [32];
    logic       obs_fs  [32];
    logic       obs_pend[32];

    digit_scan #(
        .NUM_DIGITS    (4),
        .SCAN_DIV      (8),
        .GHOST_CYC     (2),
        .EN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .lzb_en      (lzb_en),
        .dec         (dec),
        .dp_o        (dp_o),
        .digit_en    (digit_en),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic push_value(input logic [15:0] v, input logic [3:0] p);
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back({v[4*d +: 4], p[d], 1'b1});
        end
    endtask

    task automatic push_slot(input logic [3:0] v, input logic p, input logic on);
        exp_q.push_back({v, p, on});
    endtask

    // Waits (bounded) for the next frame_start, sampled at negedge.
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
        end
    endtask

    // Records one frame: sample r is slot count (r+1)%8 of digit (r+1)/8.
    task automatic capture_frame(output int waited);
        wait_fs(waited);
        for (int r = 0; r < 32; r++) begin
            if (r > 0) @(negedge clk);
            obs_dec[r]  = dec;
            obs_dp[r]   = dp_o;
            obs_en[r]   = digit_en;
            obs_fs[r]   = frame_start;
            obs_pend[r] = pending;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dec, dp_o, digit_en, pending, frame_start} !== 11'b0) begin
            errors++;
            $display("FAIL reset_values: dec=%h dp=%b en=%b pend=%b fs=%b expected all 0",
                     dec, dp_o, digit_en, pending, frame_start);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int w;
        logic fs_extra;
        push_value(16'h0000, 4'b0000);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL scan_idle d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        fs_extra = 1'b0;
        for (int r = 1; r < 32; r++) fs_extra |= obs_fs[r];
        checks++;
        if (fs_extra !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_single: extra pulse inside frame=%b expected 0", fs_extra);
        end
        capture_frame(w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL frame_period: next pulse after %0d cycles expected 1 (32-cycle period)", w);
        end
    endtask

    task automatic test_load_mid();
        int w;
        wait_fs(w);
        repeat (10) @(negedge clk);
        bcd_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL load_mid_pending: pending=%b expected 1", pending);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (dec !== 4'h0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL load_mid_hold: dec=%h pend=%b expected dec=0 pend=1", dec, pending);
        end
        push_value(16'h1234, 4'b0000);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL load_mid d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        checks++;
        if (obs_pend[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_mid_clear: pending=%b after boundary expected 0", obs_pend[0]);
        end
    endtask

    task automatic test_two_loads();
        int w;
        wait_fs(w);
        repeat (4) @(negedge clk);
        bcd_in = 16'h1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        bcd_in = 16'h5678; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL two_loads_pending: pending=%b expected 1", pending);
        end
        push_value(16'h5678, 4'b0000);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL two_loads d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
    endtask

    task automatic test_lzb();
        int w;
        lzb_en = 1'b1;
        wait_fs(w);
        repeat (5) @(negedge clk);
        bcd_in = 16'h0040; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_slot(4'h0, 1'b0, 1'b1);
        push_slot(4'h4, 1'b0, 1'b1);
        push_slot(4'h0, 1'b0, 1'b0);
        push_slot(4'h0, 1'b0, 1'b0);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL lzb_blank d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        repeat (3) @(negedge clk);
        dp_in = 4'b1000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        dp_in = 4'b0000;
        push_slot(4'h0, 1'b0, 1'b1);
        push_slot(4'h4, 1'b0, 1'b1);
        push_slot(4'h0, 1'b0, 1'b1);
        push_slot(4'h0, 1'b1, 1'b1);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL lzb_dp d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_load_boundary();
        int w;
        logic pend_seen;
        wait_fs(w);
        repeat (30) @(negedge clk);
        bcd_in = 16'h5678; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_pending: pending=%b expected 0", pending);
        end
        push_value(16'h5678, 4'b0000);
        capture_frame(w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL boundary_same_frame: frame began %0d cycles later expected 1", w);
        end
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL boundary_load d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        pend_seen = 1'b0;
        for (int r = 0; r < 32; r++) pend_seen |= obs_pend[r];
        checks++;
        if (pend_seen !== 1'b0) begin
            errors++;
            $display("FAIL boundary_pending_frame: pending seen=%b expected 0", pend_seen);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        logic pend_seen;
        wait_fs(w);
        repeat (4) @(negedge clk);
        bcd_in = 16'h1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (pending !== 1'b1 || digit_en !== 4'b0010 || dec !== 4'h7) begin
            errors++;
            $display("FAIL pre_reset: pend=%b en=%b dec=%h expected pend=1 en=0010 dec=7",
                     pending, digit_en, dec);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dec, dp_o, digit_en, pending, frame_start} !== 11'b0) begin
            errors++;
            $display("FAIL reset_async: dec=%h dp=%b en=%b pend=%b fs=%b expected all 0",
                     dec, dp_o, digit_en, pending, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_value(16'h0000, 4'b0000);
        capture_frame(w);
        for (int d = 0; d < 4; d++) begin
            slot_exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) begin
                logic [3:0] en_exp;
                en_exp = (e.on && s >= 2) ? 4'(1 << d) : 4'b0000;
                checks++;
                if (obs_dec[8*d+s] !== e.dec || obs_dp[8*d+s] !== e.dp || obs_en[8*d+s] !== en_exp) begin
                    errors++;
                    $display("FAIL after_reset d%0d s%0d: dec=%h dp=%b en=%b expected dec=%h dp=%b en=%b",
                             d, s, obs_dec[8*d+s], obs_dp[8*d+s], obs_en[8*d+s], e.dec, e.dp, en_exp);
                end
            end
        end
        pend_seen = 1'b0;
        for (int r = 0; r < 32; r++) pend_seen |= obs_pend[r];
        checks++;
        if (pend_seen !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_pending: pending seen=%b expected 0", pend_seen);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_mid();
        test_two_loads();
        test_lzb();
        test_load_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_scan.md
Name: digit_scan

Overview:
- Upstream driver for the registered 7-segment decoder in the rpm-counter display path.
- Holds a multi-digit BCD value and time-multiplexes it: one digit code and decimal point at a time go to the decoder, and the matching common-digit enable drives the display.
- Provides frame-synchronous value update, leading-zero blanking, and anti-ghosting dead time.

Parameters:
- NUM_DIGITS, 4: digits on the display; digit 0 is the least significant and rightmost.
- SCAN_DIV, 1000: clk cycles per digit slot; legal when SCAN_DIV >= GHOST_CYC+2.
- GHOST_CYC, 16: dead-time cycles at the start of each slot, during which all enables are off; legal when >= 1.
- EN_ACTIVE_LOW, 0: 1 inverts digit_en for common-anode PNP drivers.

Ports:
- clk, in, 1: single system clock.
- rst_n, in, 1: asynchronous active-low reset.
- bcd_in, in, 4*NUM_DIGITS: packed BCD value; digit i is bcd_in[4i+3:4i].
- dp_in, in, NUM_DIGITS: per-digit decimal point request.
- load, in, 1: one-cycle strobe; samples bcd_in and dp_in.
- lzb_en, in, 1: enables leading-zero blanking; treated as static.
- dec, out, 4: BCD code of the current digit, to the decoder.
- dp_o, out, 1: decimal point of the current digit, to the decoder.
- digit_en, out, NUM_DIGITS: one-hot digit enable, aligned to the decoder output.
- pending, out, 1: a loaded value is waiting for the next frame boundary.
- frame_start, out, 1: one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (async assert, sync release) sets: slot counter 0, digit index 0, shadow and staged registers 0, pending 0, dec 0, dp_o 0, frame_start 0, and digit_en inactive (all 0, or all 1 if EN_ACTIVE_LOW). Reset mid-frame discards both the displayed value and any staged value.
- Slot counter: width $clog2(SCAN_DIV). Counts 0..SCAN_DIV-1, then wraps to 0 and advances the digit index 0,1,..,NUM_DIGITS-1,0.
- Frame boundary: the cycle where the slot counter wraps and the digit index goes from NUM_DIGITS-1 to 0.
- Load handshake:
  - On load, the staged register takes bcd_in and dp_in, and pending is set.
  - Further loads before the boundary overwrite the staged value; the last one wins.
  - At a frame boundary with pending=1, the shadow register takes the staged value and pending clears.
  - If load coincides with a frame boundary, bcd_in and dp_in go straight to the shadow register and pending stays 0.
  - The displayed value never changes mid-frame.
- dec and dp_o are registered. They update on the cycle the slot counter is 0 and hold the current digit's shadow nibble and dp bit for the whole slot. frame_start is registered in the same cycle.
- Leading-zero blanking: digit i>0 is blanked when lzb_en=1 and every shadow digit from NUM_DIGITS-1 down to i is 0 with its dp bit 0. Digit 0 is never blanked. A blanked digit keeps digit_en inactive for its whole slot; dec still presents 0.
- Enable timing:
  - An internal enable is true for slot counts GHOST_CYC..SCAN_DIV-1 when the digit is not blanked.
  - digit_en is that enable registered one extra cycle, to match the decoder's one-cycle latency.
  - Result: digit_en for digit k is active from slot count GHOST_CYC+1 through count 0 of the following slot.
  - At most one bit of digit_en is ever active.
- Codes 10..15 in BCD are passed through unmodified; this block neither flags nor blanks them.

Decomposition:
- Shared package display_pkg holds:
  - DIGIT_W=4;
  - the enable-polarity helper function;
  - default SCAN_DIV and GHOST_CYC constants, also used by the rpm top level.
- One sub-module, scan_timer, holds the slot counter and digit index and emits slot_zero, slot_en_window and frame_boundary. Blanking, shadow/staged registers and output registers stay in digit_scan.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, GHOST_CYC=2, EN_ACTIVE_LOW=0):
- Reset release, no load, lzb_en=0:
  - dec=0 for every digit;
  - digit_en steps 0001,0010,0100,1000;
  - each bit is active from slot count 3 through count 0 of the next slot, and all bits are 0 at counts 1-2;
  - frame_start pulses every 32 cycles.
- load bcd_in=16'h1234 mid-frame:
  - pending=1 until the boundary;
  - the next frame shows dec 4,3,2,1 in digit order.
- Two loads in one frame, 16'h1111 then 16'h5678: only 5678 is displayed, from the next frame.
- load 16'h5678 exactly on the frame-boundary cycle: displayed in the frame starting that cycle; pending never asserts.
- lzb_en=1 with bcd 16'h0040:
  - digits 3 and 2 have digit_en 0 for their whole slots;
  - digits 1 and 0 are enabled with dec 4 and 0.
  - With dp_in=4'b1000, digit 3 is enabled, showing 0 with dp.
- Assert rst_n low mid-slot with pending=1: all outputs return to reset values immediately; after release the display shows all zeros and pending=0.
